// File: rtl/i2c_host_pkg.sv
// rtl/i2c_host_pkg.sv - shared encodings for the byte-level I2C host master
package i2c_host_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } qtr_t;

endpackage

// File: rtl/i2c_qtr_timer.sv
// rtl/i2c_qtr_timer.sv - SCL quarter-period tick generator with clock-stretch hold
module i2c_qtr_timer #(
    parameter int QTR_DIV = 125,
    parameter int CNT_W   = 16
) (
    input  logic sys_clk,
    input  logic io_resetb,
    input  logic run,
    input  logic hold,
    output logic tick
);

    logic [CNT_W-1:0] r_cnt;

    assign tick = run & ~hold & (r_cnt == CNT_W'(QTR_DIV - 1));

    // Holding at zero while stretched restarts the full quarter once SCL is seen high.
    always_ff @(posedge sys_clk or negedge io_resetb) begin
        if (!io_resetb) begin
            r_cnt <= '0;
        end else if (!run || hold || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_host_master.sv
// rtl/i2c_host_master.sv - byte-level I2C master driving open-drain SCL/SDA from commands
module i2c_host_master
    import i2c_host_pkg::*;
#(
    parameter int QTR_DIV = 125,
    parameter int CNT_W   = 16
) (
    input  logic       sys_clk,
    input  logic       io_resetb,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    input  logic       scl_in,
    output logic       sda_oe,
    input  logic       sda_in
);

    state_t     r_state;
    qtr_t       r_qtr;
    op_t        r_op;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic       r_nack;
    logic       r_scl_oe;
    logic       r_sda_oe;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic       r_rsp_nack;

    logic w_run;
    logic w_hold;
    logic w_tick;

    assign w_run     = (r_state != S_IDLE);
    assign w_hold    = ~r_scl_oe & ~scl_in;
    assign cmd_ready = (r_state == S_IDLE) & ~r_rsp_valid;
    assign busy      = w_run;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_nack  = r_rsp_nack;
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;

    i2c_qtr_timer #(
        .QTR_DIV (QTR_DIV),
        .CNT_W   (CNT_W)
    ) u_qtr_timer (
        .sys_clk   (sys_clk),
        .io_resetb (io_resetb),
        .run       (w_run),
        .hold      (w_hold),
        .tick      (w_tick)
    );

    // Line drives are registered for the quarter being entered, so they change on the tick edge.
    always_ff @(posedge sys_clk or negedge io_resetb) begin
        if (!io_resetb) begin
            r_state     <= S_IDLE;
            r_qtr       <= Q0;
            r_op        <= OP_START;
            r_bit       <= 3'd7;
            r_sh        <= 8'h00;
            r_nack      <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_nack  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (cmd_valid && cmd_ready) begin
                    r_op       <= op_t'(cmd_op);
                    r_sh       <= cmd_wdata;
                    r_nack     <= cmd_nack;
                    r_rsp_nack <= 1'b0;
                    r_qtr      <= Q0;
                    r_bit      <= 3'd7;
                    case (op_t'(cmd_op))
                        OP_START: begin
                            r_state  <= S_START;
                            r_sda_oe <= 1'b0;
                        end
                        OP_WRITE: begin
                            r_state  <= S_BIT;
                            r_scl_oe <= 1'b1;
                            r_sda_oe <= ~cmd_wdata[7];
                        end
                        OP_READ: begin
                            r_state  <= S_BIT;
                            r_scl_oe <= 1'b1;
                            r_sda_oe <= 1'b0;
                        end
                        OP_STOP: begin
                            r_state  <= S_STOP;
                            r_scl_oe <= 1'b1;
                            r_sda_oe <= 1'b1;
                        end
                    endcase
                end
            end else if (w_tick) begin
                r_qtr <= qtr_t'(r_qtr + 2'd1);
                case (r_state)
                    S_START: begin
                        case (r_qtr)
                            Q0: r_scl_oe <= 1'b0;
                            Q1: r_sda_oe <= 1'b1;
                            Q2: r_scl_oe <= 1'b1;
                            Q3: begin
                                r_state     <= S_IDLE;
                                r_rsp_valid <= 1'b1;
                            end
                        endcase
                    end
                    S_BIT: begin
                        case (r_qtr)
                            Q0: ;
                            Q1: r_scl_oe <= 1'b0;
                            Q2: if (r_op == OP_READ) r_rsp_rdata <= {r_rsp_rdata[6:0], sda_in};
                            Q3: begin
                                r_scl_oe <= 1'b1;
                                if (r_bit == 3'd0) begin
                                    r_state  <= S_ACK;
                                    r_sda_oe <= (r_op == OP_WRITE) ? 1'b0 : ~r_nack;
                                end else begin
                                    r_bit    <= r_bit - 3'd1;
                                    r_sh     <= {r_sh[6:0], 1'b0};
                                    r_sda_oe <= (r_op == OP_WRITE) ? ~r_sh[6] : 1'b0;
                                end
                            end
                        endcase
                    end
                    S_ACK: begin
                        case (r_qtr)
                            Q0: ;
                            Q1: r_scl_oe <= 1'b0;
                            Q2: if (r_op == OP_WRITE) r_rsp_nack <= sda_in;
                            Q3: begin
                                r_scl_oe    <= 1'b1;
                                r_state     <= S_IDLE;
                                r_rsp_valid <= 1'b1;
                            end
                        endcase
                    end
                    S_STOP: begin
                        case (r_qtr)
                            Q0: r_scl_oe <= 1'b0;
                            Q1: r_sda_oe <= 1'b0;
                            Q2: ;
                            Q3: begin
                                r_state     <= S_IDLE;
                                r_rsp_valid <= 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_host_master.md
Name: i2c_host_master

Overview:
- Byte-level I2C master that drives the chip's control I2C slave pins (cscl/csda) from the host side.
- Used as the initiator in system benches and as the host-side controller in FPGA bring-up.
- Accepts START/WRITE/READ/STOP commands over a valid/ready handshake and generates open-drain SCL/SDA with quarter-period timing.
- Honours slave clock stretching and returns read data plus ACK/NACK status per byte.

Parameters:
- QTR_DIV, 125, sys_clk cycles per SCL quarter period (50 MHz sys_clk -> 100 kHz SCL); legal range 2..65535.
- CNT_W, 16, width of the quarter counter.

Ports:
- sys_clk    in   1   system clock.
- io_resetb  in   1   asynchronous active-low reset.
- cmd_valid  in   1   command present.
- cmd_ready  out  1   block accepts a command this cycle.
- cmd_op     in   2   0=START (also repeated start), 1=WRITE, 2=READ, 3=STOP.
- cmd_wdata  in   8   byte for WRITE, sent MSB first.
- cmd_nack   in   1   READ only: 1 = master sends NACK after the byte.
- rsp_valid  out  1   one-cycle pulse when any command completes.
- rsp_rdata  out  8   byte received by READ; holds its value otherwise.
- rsp_nack   out  1   WRITE: sampled slave ACK bit (1 = NACK); 0 for other ops.
- busy       out  1   command in progress.
- scl_oe     out  1   1 = pull SCL low.
- scl_in     in   1   SCL pad input.
- sda_oe     out  1   1 = pull SDA low.
- sda_in     in   1   SDA pad input.

Behaviour:
- Reset values:
  - scl_oe=0, sda_oe=0, so both lines are released immediately and asynchronously.
  - cmd_ready=1, rsp_valid=0, rsp_rdata=8'h00, rsp_nack=0, busy=0.
  - Quarter counter=0, state=IDLE.
- Handshake:
  - A command is accepted on cmd_valid & cmd_ready.
  - cmd_ready = (state==IDLE) & ~rsp_valid.
  - Inputs are registered on acceptance; busy rises the next cycle.
- Quarter timer:
  - Emits a tick every QTR_DIV cycles while the FSM is active.
  - In any quarter where SCL is released, the counter holds at 0 until scl_in==1 (stretch). Counting resumes the cycle after scl_in goes high.
- FSM states: IDLE, START, BIT, ACK, STOP. Each phase is 4 quarters Q0..Q3.
- START:
  - Q0: release SDA.
  - Q1: release SCL (stretch wait).
  - Q2: pull SDA low.
  - Q3: pull SCL low.
  - Ends -> IDLE with rsp_valid.
  - Valid from idle bus or mid-transfer (repeated start).
- BIT, 8 iterations, MSB first:
  - Q0: SCL low; WRITE drives sda_oe=~bit, READ sets sda_oe=0.
  - Q1: SCL low.
  - Q2: release SCL (stretch wait).
  - Q3: SCL high. sda_in is sampled at the Q2->Q3 tick and shifted into rsp_rdata (READ only).
  - After bit 0 -> ACK.
- ACK, same quarters:
  - WRITE: SDA released; sampled value goes to rsp_nack.
  - READ: sda_oe = ~cmd_nack.
  - End of Q3 -> IDLE with rsp_valid. SCL stays low and SDA stays at its last drive until the next command.
- STOP:
  - Q0: SCL low, SDA low.
  - Q1: release SCL (stretch wait).
  - Q2: release SDA.
  - Q3: idle hold (bus-free time).
  - Ends -> IDLE with rsp_valid; both lines released.
- Timing and latency:
  - rsp_valid is asserted in the cycle after the final Q3 tick, for exactly one cycle.
  - START/STOP take 4*QTR_DIV cycles plus stretch; WRITE/READ take 36*QTR_DIV cycles plus stretch.
- Boundary conditions:
  - WRITE/READ issued without a prior START proceeds anyway; sequencing is the caller's responsibility.
  - A NACK on WRITE does not abort; the caller issues STOP.
  - Stretch wait is unbounded; there is no timeout.
  - No multi-master arbitration. An sda_in mismatch while SDA is released is ignored.
  - cmd_valid while busy is ignored (cmd_ready=0). Held commands are not lost.
  - Reset mid-byte aborts immediately and releases the bus. No STOP is generated.

Decomposition:
- Package i2c_host_pkg holds:
  - cmd_op encodings OP_START/OP_WRITE/OP_READ/OP_STOP.
  - FSM state encoding.
  - Quarter index encoding Q0..Q3.
- Sub-module i2c_qtr_timer (QTR_DIV, CNT_W):
  - Inputs: run, hold.
  - Output: tick.
  - Behaviour: hold = SCL released & ~scl_in.

Test Plan:
1. QTR_DIV=4; START then STOP on an idle bus with pull-ups.
   - SDA falls while SCL is high, 8 cycles after acceptance.
   - STOP shows SDA rising while SCL is high.
   - Each op produces one rsp_valid pulse; both lines end released.
2. WRITE 8'hA5 to a bench slave that ACKs.
   - SDA during SCL-high windows reads 1,0,1,0,0,1,0,1.
   - rsp_nack=0; rsp_valid arrives 144 cycles after acceptance.
3. WRITE 8'h74 (address 7'h3A, write) to an absent slave.
   - rsp_nack=1; FSM returns to IDLE.
   - A following STOP completes normally.
4. READ with cmd_nack=0, slave returns 8'h3C, then READ with cmd_nack=1, slave returns 8'hFF.
   - rsp_rdata is 8'h3C, then 8'hFF.
   - Master drives SDA low in the first ACK slot and leaves it released in the second.
5. Slave holds SCL low for 50 cycles in bit 3 of a WRITE.
   - Byte completes correctly; total latency is 144+50 cycles.
   - No SCL high period is shorter than 4 cycles.
6. Deassert io_resetb during bit 5 of a READ.
   - scl_oe and sda_oe go to 0 without waiting for a clock edge.
   - After reset: cmd_ready=1 and no rsp_valid pulse.
